// File: rtl/mdio_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mdio_pkg
// Brief    : Clause-22 MDIO frame constants, FSM encoding, RTL8211E reg-17 map.
// Revision : 1.0 - initial release
//==============================================================================
package mdio_pkg;

    localparam logic [1:0] MDIO_ST   = 2'b01;
    localparam logic [1:0] OP_WR     = 2'b01;
    localparam logic [1:0] OP_RD     = 2'b10;
    localparam logic [1:0] TA_WR     = 2'b10;

    localparam int PRE_LEN   = 32;
    localparam int FRAME_LEN = 64;
    localparam int TA_BIT    = 46;
    localparam int DATA_BIT  = 48;

    localparam int RTL_LINK     = 10;
    localparam int RTL_DUPLEX   = 13;
    localparam int RTL_SPEED_HI = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_TAIL  = 2'd2
    } mdio_state_t;

    // Frame bit 0 sits in the MSB so it can be shifted out directly.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic        wr,
        input logic [4:0]  phy,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        return {{PRE_LEN{1'b1}}, MDIO_ST, (wr ? OP_WR : OP_RD), phy, regad,
                (wr ? TA_WR : 2'b00), (wr ? wdata : 16'h0000)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_bitgen.sv
`default_nettype none
//==============================================================================
// Module   : mdio_bitgen
// Brief    : MDC divider with fall/rise strobes, frame bit counter, md_i sync.
// Revision : 1.0 - initial release
//==============================================================================
module mdio_bitgen #(
    parameter int MDC_HALF = 10
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       i_active,
    input  logic       i_md,
    output logic       o_fall_tick,
    output logic       o_rise_tick,
    output logic [6:0] o_bit_cnt,
    output logic       o_mdc,
    output logic       o_md_sync
);

    localparam logic [5:0] c_DIV_LAST = 6'(2 * MDC_HALF - 1);
    localparam logic [5:0] c_RISE_AT  = 6'(MDC_HALF - 1);
    localparam logic [6:0] c_BIT_MAX  = 7'd64;

    logic [5:0] r_div;
    logic       r_sync1;

    // Strobes mark the edge at which mdc changes, so registered outputs align with it.
    assign o_fall_tick = i_active && (r_div == c_DIV_LAST);
    assign o_rise_tick = i_active && (r_div == c_RISE_AT);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_div     <= '0;
            o_bit_cnt <= '0;
            o_mdc     <= 1'b0;
            r_sync1   <= 1'b0;
            o_md_sync <= 1'b0;
        end else begin
            r_sync1   <= i_md;
            o_md_sync <= r_sync1;
            if (!i_active) begin
                r_div     <= '0;
                o_bit_cnt <= '0;
                o_mdc     <= 1'b0;
            end else if (r_div == c_DIV_LAST) begin
                r_div     <= '0;
                o_mdc     <= 1'b0;
                if (o_bit_cnt != c_BIT_MAX) begin
                    o_bit_cnt <= o_bit_cnt + 7'd1;
                end
            end else begin
                r_div <= r_div + 6'd1;
                if (r_div == c_RISE_AT) begin
                    o_mdc <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdio_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : mdio_ctrl
// Brief    : Clause-22 MDIO controller, host commands plus periodic PHY status poll.
// Revision : 1.0 - initial release
//==============================================================================
module mdio_ctrl
    import mdio_pkg::*;
#(
    parameter int         MDC_HALF = 10,
    parameter logic [4:0] POLL_PHY = 5'd1,
    parameter logic [4:0] POLL_REG = 5'd17
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        cmd_ack,
    output logic        cmd_done,
    output logic [15:0] cmd_rdata,
    output logic        busy,
    input  logic        poll_en,
    input  logic        poll_evt,
    output logic        stat_valid,
    output logic        stat_link,
    output logic [1:0]  stat_speed,
    output logic        stat_duplex,
    output logic        mdc,
    output logic        md_o,
    output logic        md_oe,
    input  logic        md_i
);

    mdio_state_t r_state;
    logic        r_host;
    logic        r_wr;
    logic [63:0] r_sh;
    logic [15:0] r_rx;
    logic        r_poll_pend;
    logic        r_rise_d1;
    logic        r_rise_d2;

    logic        w_fall;
    logic        w_rise;
    logic [6:0]  w_bit;
    logic        w_md_sync;
    logic        w_host_start;
    logic        w_poll_start;
    logic [63:0] w_frame;

    mdio_bitgen #(
        .MDC_HALF (MDC_HALF)
    ) u_bitgen (
        .clock       (clock),
        .rst         (rst),
        .i_active    (r_state != ST_IDLE),
        .i_md        (md_i),
        .o_fall_tick (w_fall),
        .o_rise_tick (w_rise),
        .o_bit_cnt   (w_bit),
        .o_mdc       (mdc),
        .o_md_sync   (w_md_sync)
    );

    always_comb begin
        w_host_start = (r_state == ST_IDLE) && cmd_req;
        w_poll_start = (r_state == ST_IDLE) && !cmd_req && r_poll_pend && poll_en;
        w_frame      = w_host_start ? build_frame(cmd_wr, cmd_phy, cmd_reg, cmd_wdata)
                                    : build_frame(1'b0, POLL_PHY, POLL_REG, 16'h0000);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_host      <= 1'b0;
            r_wr        <= 1'b0;
            r_sh        <= '0;
            r_rx        <= '0;
            r_poll_pend <= 1'b0;
            r_rise_d1   <= 1'b0;
            r_rise_d2   <= 1'b0;
            cmd_ack     <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_rdata   <= '0;
            busy        <= 1'b0;
            stat_valid  <= 1'b0;
            stat_link   <= 1'b0;
            stat_speed  <= '0;
            stat_duplex <= 1'b0;
            md_o        <= 1'b0;
            md_oe       <= 1'b0;
        end else begin
            cmd_ack   <= 1'b0;
            cmd_done  <= 1'b0;
            r_rise_d1 <= w_rise;
            r_rise_d2 <= r_rise_d1;

            if (!poll_en || w_poll_start) begin
                r_poll_pend <= 1'b0;
            end else if (poll_evt) begin
                r_poll_pend <= 1'b1;
            end

            // Two clocks after the mdc rise the synchroniser holds the bit the PHY drove.
            if ((r_state == ST_FRAME) && r_rise_d2 && (w_bit >= 7'(DATA_BIT))) begin
                r_rx <= {r_rx[14:0], w_md_sync};
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_host_start || w_poll_start) begin
                        r_state <= ST_FRAME;
                        busy    <= 1'b1;
                        r_host  <= w_host_start;
                        r_wr    <= w_host_start && cmd_wr;
                        cmd_ack <= w_host_start;
                        md_o    <= w_frame[63];
                        md_oe   <= 1'b1;
                        r_sh    <= {w_frame[62:0], 1'b0};
                    end
                end
                ST_FRAME: begin
                    if (w_fall) begin
                        if (w_bit == 7'(FRAME_LEN - 1)) begin
                            r_state <= ST_TAIL;
                            md_o    <= 1'b0;
                            md_oe   <= 1'b0;
                        end else begin
                            md_o  <= r_sh[63];
                            r_sh  <= {r_sh[62:0], 1'b0};
                            md_oe <= r_wr || ((w_bit + 7'd1) < 7'(TA_BIT));
                        end
                    end
                end
                ST_TAIL: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        if (r_host) begin
                            cmd_done <= 1'b1;
                            if (!r_wr) begin
                                cmd_rdata <= r_rx;
                            end
                        end else begin
                            stat_valid  <= 1'b1;
                            stat_link   <= r_rx[RTL_LINK];
                            stat_duplex <= r_rx[RTL_DUPLEX];
                            stat_speed  <= r_rx[RTL_SPEED_HI -: 2];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_mdio_ctrl
// Brief    : Self-checking bench for mdio_ctrl with a behavioural PHY responder.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mdio_ctrl;

    localparam int H          = 10;
    localparam int BIT_CLKS   = 2 * H;
    localparam int FRAME_CLKS = 65 * BIT_CLKS;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_req = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [4:0]  cmd_phy = '0;
    logic [4:0]  cmd_reg = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_ack, cmd_done, busy;
    logic [15:0] cmd_rdata;
    logic        poll_en = 1'b0;
    logic        poll_evt = 1'b0;
    logic        stat_valid, stat_link, stat_duplex;
    logic [1:0]  stat_speed;
    logic        mdc, md_o, md_oe;
    logic        md_i = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] q_stream[$];
    logic [63:0] q_oe[$];
    logic [15:0] q_data[$];

    localparam logic [63:0] OE_WR = {64{1'b1}};
    localparam logic [63:0] OE_RD = {{46{1'b1}}, {18{1'b0}}};

    mdio_ctrl #(
        .MDC_HALF (H),
        .POLL_PHY (5'd1),
        .POLL_REG (5'd17)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .cmd_req     (cmd_req),
        .cmd_wr      (cmd_wr),
        .cmd_phy     (cmd_phy),
        .cmd_reg     (cmd_reg),
        .cmd_wdata   (cmd_wdata),
        .cmd_ack     (cmd_ack),
        .cmd_done    (cmd_done),
        .cmd_rdata   (cmd_rdata),
        .busy        (busy),
        .poll_en     (poll_en),
        .poll_evt    (poll_evt),
        .stat_valid  (stat_valid),
        .stat_link   (stat_link),
        .stat_speed  (stat_speed),
        .stat_duplex (stat_duplex),
        .mdc         (mdc),
        .md_o        (md_o),
        .md_oe       (md_oe),
        .md_i        (md_i)
    );

    always #10 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_frame(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] rg, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg,
                (wr ? 2'b10 : 2'b00), (wr ? d : 16'h0000)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered on the first FRAME clock; returns on the clock after the frame ends.
    task automatic run_frame(input logic [15:0] phy_data, input bit pulse_evts,
                             output logic [63:0] cap_md, output logic [63:0] cap_oe,
                             output int n_done, output int n_bad);
        cap_md = '0;
        cap_oe = '0;
        n_done = 0;
        n_bad  = 0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
            int ph;
            int b;
            ph = k % BIT_CLKS;
            b  = k / BIT_CLKS;
            if (mdc !== (ph >= H)) n_bad++;
            if (busy !== 1'b1) n_bad++;
            if (cmd_done === 1'b1) n_done++;
            if (ph == 0) begin
                md_i = (b >= 48 && b < 64) ? phy_data[63 - b] : 1'b1;
                if (b < 64) cap_oe[63 - b] = md_oe;
            end
            if (ph == H / 2 && b < 64) cap_md[63 - b] = md_o;
            if (b == 64 && md_oe !== 1'b0) n_bad++;
            poll_evt = pulse_evts && (k % 400 == 200);
            tick();
        end
        poll_evt = 1'b0;
        md_i     = 1'b1;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] d);
        cmd_wr    = wr;
        cmd_phy   = phy;
        cmd_reg   = rg;
        cmd_wdata = d;
        cmd_req   = 1'b1;
    endtask

    task automatic test_reset();
        int nb;
        rst      = 1'b1;
        poll_en  = 1'b1;
        poll_evt = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if ({cmd_ack, cmd_done, busy, mdc, md_o, md_oe} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", {cmd_ack, cmd_done, busy, mdc, md_o, md_oe});
        end
        n_tests++;
        if ({cmd_rdata, stat_valid, stat_link, stat_speed, stat_duplex} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h stat %b required 0", cmd_rdata,
                     {stat_valid, stat_link, stat_speed, stat_duplex});
        end
        poll_evt = 1'b0;
        rst      = 1'b0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0) nb++;
        end
        n_tests++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL reset_evt_ignored: busy cycles %0d required 0", nb);
        end
        poll_en = 1'b0;
    endtask

    task automatic test_write();
        logic [63:0] cm, co, es, eo;
        int nd, nb;
        q_stream.push_back(exp_frame(1'b1, 5'd1, 5'd0, 16'h1140));
        q_oe.push_back(OE_WR);
        issue_cmd(1'b1, 5'd1, 5'd0, 16'h1140);
        tick();
        n_tests++;
        if (cmd_ack !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ack: ack %b busy %b required 1 1", cmd_ack, busy);
        end
        cmd_req = 1'b0;
        run_frame(16'h0000, 1'b0, cm, co, nd, nb);
        es = q_stream.pop_front();
        eo = q_oe.pop_front();
        n_tests++;
        if (cm !== es) begin
            n_fail++;
            $display("FAIL wr_stream: got %h required %h", cm, es);
        end
        n_tests++;
        if (co !== eo) begin
            n_fail++;
            $display("FAIL wr_oe: got %h required %h", co, eo);
        end
        n_tests++;
        if (nb !== 0 || nd !== 0) begin
            n_fail++;
            $display("FAIL wr_timing: shape errors %0d early done %0d required 0 0", nb, nd);
        end
        n_tests++;
        if ({cmd_done, busy, mdc, md_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_done: done/busy/mdc/oe %b required 1000", {cmd_done, busy, mdc, md_oe});
        end
        tick();
        n_tests++;
        if (cmd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_pulse: got %b required 0", cmd_done);
        end
    endtask

    task automatic test_read(input logic [4:0] rg, input logic [15:0] d);
        logic [63:0] cm, co, es, eo;
        logic [15:0] ed;
        int nd, nb;
        q_stream.push_back(exp_frame(1'b0, 5'd1, rg, 16'h0));
        q_oe.push_back(OE_RD);
        q_data.push_back(d);
        issue_cmd(1'b0, 5'd1, rg, 16'h0);
        tick();
        n_tests++;
        if (cmd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ack: got %b required 1", cmd_ack);
        end
        cmd_req = 1'b0;
        run_frame(d, 1'b0, cm, co, nd, nb);
        es = q_stream.pop_front();
        eo = q_oe.pop_front();
        ed = q_data.pop_front();
        n_tests++;
        if (cm[63:18] !== es[63:18] || co !== eo) begin
            n_fail++;
            $display("FAIL rd_stream: got %h oe %h required %h oe %h", cm, co, es, eo);
        end
        n_tests++;
        if (nb !== 0 || nd !== 0) begin
            n_fail++;
            $display("FAIL rd_timing: shape errors %0d early done %0d required 0 0", nb, nd);
        end
        n_tests++;
        if (cmd_done !== 1'b1 || cmd_rdata !== ed) begin
            n_fail++;
            $display("FAIL rd_data: done %b rdata %h required 1 %h", cmd_done, cmd_rdata, ed);
        end
    endtask

    task automatic poll_frame(input logic [15:0] d, input string tag);
        logic [63:0] cm, co, es, eo;
        logic [15:0] ed;
        int nd, nb;
        bit ok;
        wait_busy(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_start: busy %b required 1 within 20 clocks", tag, busy);
            return;
        end
        q_stream.push_back(exp_frame(1'b0, 5'd1, 5'd17, 16'h0));
        q_oe.push_back(OE_RD);
        q_data.push_back(d);
        run_frame(d, 1'b0, cm, co, nd, nb);
        es = q_stream.pop_front();
        eo = q_oe.pop_front();
        ed = q_data.pop_front();
        n_tests++;
        if (cm[63:18] !== es[63:18] || co !== eo || nb !== 0) begin
            n_fail++;
            $display("FAIL %s_stream: got %h oe %h errs %0d required %h oe %h", tag, cm, co, nb, es, eo);
        end
        n_tests++;
        if ({stat_valid, stat_link, stat_speed, stat_duplex} !== {1'b1, ed[10], ed[15:14], ed[13]}
            || nd !== 0 || cmd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stat: v/l/s/d %b done %0d/%b required %b no done", tag,
                     {stat_valid, stat_link, stat_speed, stat_duplex}, nd, cmd_done,
                     {1'b1, ed[10], ed[15:14], ed[13]});
        end
    endtask

    task automatic test_poll();
        n_tests++;
        if (stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL poll_prevalid: got %b required 0", stat_valid);
        end
        poll_en  = 1'b1;
        poll_evt = 1'b1;
        tick();
        poll_evt = 1'b0;
        poll_frame(16'hAC00, "poll");
        n_tests++;
        if (stat_speed !== 2'b10 || stat_duplex !== 1'b1 || stat_link !== 1'b1) begin
            n_fail++;
            $display("FAIL poll_decode: speed %b duplex %b link %b required 10 1 1",
                     stat_speed, stat_duplex, stat_link);
        end
    endtask

    task automatic test_collision();
        logic [63:0] cm, co, es;
        int nd, nb, nbusy;
        q_stream.push_back(exp_frame(1'b1, 5'd3, 5'd4, 16'hBEEF));
        issue_cmd(1'b1, 5'd3, 5'd4, 16'hBEEF);
        poll_evt = 1'b1;
        tick();
        poll_evt = 1'b0;
        cmd_req  = 1'b0;
        n_tests++;
        if (cmd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL col_host_first: ack %b required 1", cmd_ack);
        end
        run_frame(16'h0000, 1'b1, cm, co, nd, nb);
        es = q_stream.pop_front();
        n_tests++;
        if (cm !== es || cmd_done !== 1'b1 || nb !== 0) begin
            n_fail++;
            $display("FAIL col_host_frame: got %h done %b errs %0d required %h done 1", cm, cmd_done, nb, es);
        end
        poll_frame(16'h0400, "col_poll");
        nbusy = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy !== 1'b0) nbusy++;
            tick();
        end
        n_tests++;
        if (nbusy !== 0) begin
            n_fail++;
            $display("FAIL col_single_poll: extra busy cycles %0d required 0", nbusy);
        end
    endtask

    task automatic test_poll_disabled();
        int nbusy;
        poll_en = 1'b0;
        nbusy   = 0;
        for (int i = 0; i < 300; i++) begin
            poll_evt = (i % 50 == 5);
            tick();
            if (busy !== 1'b0) nbusy++;
        end
        poll_evt = 1'b0;
        poll_en  = 1'b1;
        poll_evt = 1'b1;
        tick();
        poll_evt = 1'b0;
        poll_en  = 1'b0;
        tick();
        poll_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b0) nbusy++;
        end
        poll_en = 1'b0;
        n_tests++;
        if (nbusy !== 0) begin
            n_fail++;
            $display("FAIL poll_disabled: busy cycles %0d required 0", nbusy);
        end
    endtask

    task automatic test_reset_midframe();
        int nbad;
        issue_cmd(1'b0, 5'd1, 5'd3, 16'h0);
        tick();
        cmd_req = 1'b0;
        for (int k = 0; k < 40 * BIT_CLKS + H + 5; k++) tick();
        n_tests++;
        if ({mdc, md_oe, busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL rstmid_pre: mdc/oe/busy %b required 111", {mdc, md_oe, busy});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({mdc, md_oe, busy, cmd_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_abort: mdc/oe/busy/done %b required 0000", {mdc, md_oe, busy, cmd_done});
        end
        nbad = 0;
        for (int i = 0; i < FRAME_CLKS + 100; i++) begin
            tick();
            if (cmd_done !== 1'b0 || busy !== 1'b0) nbad++;
        end
        n_tests++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: done/busy cycles %0d required 0", nbad);
        end
        test_read(5'd5, 16'h5A3C);
    endtask

    initial begin
        test_reset();
        test_write();
        tick();
        test_read(5'd2, 16'h001C);
        tick();
        test_poll();
        tick();
        test_collision();
        test_poll_disabled();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdio_ctrl.md
Name: mdio_ctrl

Overview:
- Clause-22 MDIO management controller for the RTL8211EG PHY. Runs on the 50 MHz system clock.
- Generates MDC internally as a divided, gated clock output.
- Arbitrates between two requesters and serialises 64-bit frames on MDC/MDIO:
  - host register read/write commands;
  - periodic PHY status polls triggered by the slow MD event tick.
- Decoded link status is presented to the Ethernet core.

Parameters:
- MDC_HALF, 10, system clocks per MDC half-period (10 gives 400 ns MDC at 50 MHz); legal range 4..31.
- POLL_PHY, 5'd1, PHY address used by the status poll.
- POLL_REG, 5'd17, register read by the poll (RTL8211E PHY-specific status).

Ports:
- clock  in  1  system clock, 50 MHz
- rst  in  1  reset
- cmd_req  in  1  host command request, level; held until cmd_ack
- cmd_wr  in  1  1=write, 0=read; sampled with cmd_req
- cmd_phy  in  5  PHY address
- cmd_reg  in  5  register address
- cmd_wdata  in  16  write data
- cmd_ack  out  1  one-cycle pulse when the host command is accepted
- cmd_done  out  1  one-cycle pulse when the host frame completes
- cmd_rdata  out  16  read data; valid from cmd_done until the next host read completes
- busy  out  1  frame in progress
- poll_en  in  1  enables status polling
- poll_evt  in  1  poll trigger, one-cycle pulse
- stat_valid  out  1  set after the first completed poll, sticky until reset
- stat_link  out  1  reg17[10]
- stat_speed  out  2  reg17[15:14]
- stat_duplex  out  1  reg17[13]
- mdc  out  1  management clock
- md_o  out  1  MDIO output data
- md_oe  out  1  MDIO output enable
- md_i  in  1  MDIO input, asynchronous

Behaviour:
- Single clock domain `clock`. Reset `rst` is synchronous and active-high.
- Reset values:
  - all outputs 0; cmd_rdata and stat_* 0;
  - FSM in IDLE, pending poll cleared, divider 0.
  - Reset mid-frame aborts immediately: mdc=0, md_oe=0 on the next edge, no cmd_done.
- Poll latch:
  - poll_evt && poll_en sets poll_pend.
  - Multiple events while pending collapse into one.
  - Clearing poll_en clears poll_pend.
- Arbitration happens in IDLE only:
  - host has priority over poll;
  - cmd_ack pulses in the cycle the host command is latched (phy, reg, wr, wdata captured);
  - poll_pend clears when a poll starts;
  - a poll_evt arriving during a host frame is serviced right after it.
- FSM states: IDLE -> FRAME -> TAIL -> IDLE.
  - busy=1 outside IDLE.
  - No new request is accepted until the FSM is back in IDLE for at least one clock.
- MDC generation:
  - divider runs only outside IDLE; mdc is held 0 in IDLE;
  - each bit period = MDC_HALF clocks low followed by MDC_HALF clocks high, so period = 2*MDC_HALF clocks.
- Frame: bits 0..63, MSB first per field.
  - bits 0..31: preamble, all 1
  - bits 32..33: ST = 01
  - bits 34..35: OP (01 write, 10 read)
  - bits 36..40: PHYAD
  - bits 41..45: REGAD
  - bits 46..47: TA
  - bits 48..63: DATA
- Drive rules:
  - md_o/md_oe update in the clock where mdc falls, i.e. at the start of each bit period; the first bit is driven on the first FRAME clock.
  - Write frame: md_oe=1 for bits 0..63; TA driven as 10.
  - Read frame: md_oe=1 for bits 0..45 and 0 from bit 46 onward.
- Read sampling:
  - md_i passes through a 2-FF synchroniser.
  - The synchronised value is sampled exactly 2 clocks after each mdc rise in bits 48..63 and shifted MSB first.
- TAIL: one bit period with md_oe=0 and mdc running, then mdc=0.
- Completion, in the same clock as the TAIL->IDLE transition:
  - host frame: cmd_done pulses; on a read, cmd_rdata updates in that same clock;
  - poll frame: stat_* update and stat_valid is set.
- Frame duration: 65*2*MDC_HALF clocks from the first FRAME clock to the IDLE transition (1300 clocks at default).
- cmd_req deasserted before ack means no transaction.
- poll_evt in the same clock as a reset is ignored.

Decomposition:
- Package mdio_pkg holds:
  - ST/OP codes (MDIO_ST=2'b01, OP_WR=2'b01, OP_RD=2'b10), PRE_LEN=32, FRAME_LEN=64;
  - FSM state encoding;
  - RTL8211E reg-17 bit positions (LINK=10, DUPLEX=13, SPEED_HI=15).
- One sub-module, mdio_bitgen: MDC divider producing fall_tick/rise_tick strobes, bit counter 0..64, and the 2-FF md_i synchroniser.
- mdio_ctrl keeps arbitration, the frame shift register, and the status decode.

Test Plan:
- Write: cmd_req with wr=1, phy=1, reg=0, wdata=16'h1140 -> cmd_ack 1 cycle after req; MDIO stream = 32 ones, 01 01 00001 00000 10 0001000101000000; md_oe never drops during the frame; cmd_done after 1300 clocks.
- Read: phy=1, reg=2; bench PHY model drives 16'h001C after TA -> md_oe=0 from bit 46; cmd_rdata=16'h001C at cmd_done.
- Poll: poll_en=1, poll_evt pulse; model returns reg17=16'hAC00 -> frame targets phy 1, reg 17; stat_speed=2'b10, stat_duplex=1, stat_link=1, stat_valid=1.
- Collision: poll_evt and cmd_req in the same cycle, plus 3 extra poll_evt during the host frame -> host frame first, then exactly one poll frame.
- Reset mid-frame: assert rst at bit 40 -> next clock mdc=0, md_oe=0, busy=0, no cmd_done; a new read then completes normally.
- poll_en=0: poll_evt pulses -> no frame, busy stays 0.
